// File: rtl/vga_timing_recover_if.sv
// VGA pixel stream bundle shared between timing generator, draw stages and
// sinks. Counters travel alongside the blanking flags, but sinks that must
// not trust them only look at the flags.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_recover.sv
// Stream checker and coordinate recovery for a VGA pixel stream.
// Pixel coordinates are rebuilt purely from blanking-flag falling edges;
// line and frame lengths are measured against the expected totals, lock
// is declared after a run of clean frames, and timing faults seen while
// locked are counted.
module vga_timing_recover #(
    parameter int H_TOTAL     = 1344,
    parameter int V_TOTAL     = 806,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        de,
    output logic [11:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] h_total_meas,
    output logic [10:0] v_total_meas,
    output logic [7:0]  err_count
);

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);
    localparam logic [7:0]  ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic        hb_q, hb_d;
    logic        vb_q, vb_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [7:0]  good_q, good_d;
    logic        h_seen_q, h_seen_d;
    logic        frame_bad_q, frame_bad_d;
    logic        de_q, de_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic [10:0] h_meas_q, h_meas_d;
    logic [10:0] v_meas_q, v_meas_d;
    logic [7:0]  err_q, err_d;

    logic        line_start;
    logic        frame_edge;
    logic        line_err;
    logic        frame_err;
    logic        timeout_err;
    logic        frame_clean;
    logic [7:0]  good_inc;

    // Upstream counters are deliberately ignored; fold them into a sink net.
    logic unused_counts;
    assign unused_counts = ^{in.hcount, in.vcount};

    // Edge detection, counters, measurements, error detection and lock FSM.
    always_comb begin
        line_start  = hb_q && !in.hblnk;
        frame_edge  = vb_q && !in.vblnk;
        line_err    = line_start && h_seen_q && (h_cnt_q != H_LAST);
        frame_err   = frame_edge && (v_cnt_q != V_LAST) && (state_q != SEARCH);
        timeout_err = (h_cnt_q == CNT_MAX) && (state_q == LOCKED);
        frame_clean = !frame_err && !frame_bad_q && !line_err;
        good_inc    = good_q + 8'd1;

        state_d       = state_q;
        good_d        = good_q;
        err_d         = err_q;
        h_meas_d      = h_meas_q;
        v_meas_d      = v_meas_q;
        h_seen_d      = h_seen_q;
        frame_bad_d   = frame_bad_q;

        hb_d          = in.hblnk;
        vb_d          = in.vblnk;
        de_d          = !in.hblnk && !in.vblnk;
        rgb_d         = in.rgb;
        hsync_d       = in.hsync;
        vsync_d       = in.vsync;
        frame_start_d = frame_edge;

        if (line_start) begin
            h_cnt_d = 11'd0;
        end else if (h_cnt_q == CNT_MAX) begin
            h_cnt_d = CNT_MAX;
        end else begin
            h_cnt_d = h_cnt_q + 11'd1;
        end

        if (frame_edge) begin
            v_cnt_d = 11'd0;
        end else if (line_start) begin
            v_cnt_d = (v_cnt_q == CNT_MAX) ? CNT_MAX : v_cnt_q + 11'd1;
        end else begin
            v_cnt_d = v_cnt_q;
        end

        if (line_start && h_seen_q) begin
            h_meas_d = h_cnt_q + 11'd1;
        end
        if (line_start) begin
            h_seen_d = 1'b1;
        end

        if (frame_edge) begin
            v_meas_d = v_cnt_q + 11'd1;
        end

        if (frame_edge) begin
            frame_bad_d = 1'b0;
        end else if (line_err) begin
            frame_bad_d = 1'b1;
        end

        case (state_q)
            SEARCH: begin
                if (frame_edge) begin
                    state_d = MEASURE;
                    good_d  = 8'd0;
                end
            end
            MEASURE: begin
                if (frame_edge) begin
                    if (frame_clean) begin
                        good_d = good_inc;
                        if (good_inc >= LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = 8'd0;
                    end
                end
            end
            LOCKED: begin
                if (line_err || frame_err || timeout_err) begin
                    err_d    = (err_q == ERR_MAX) ? ERR_MAX : err_q + 8'd1;
                    state_d  = SEARCH;
                    good_d   = 8'd0;
                    h_seen_d = 1'b0;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    // State register bank; synchronous reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SEARCH;
            hb_q          <= 1'b0;
            vb_q          <= 1'b0;
            h_cnt_q       <= 11'd0;
            v_cnt_q       <= 11'd0;
            good_q        <= 8'd0;
            h_seen_q      <= 1'b0;
            frame_bad_q   <= 1'b0;
            de_q          <= 1'b0;
            rgb_q         <= 12'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            h_meas_q      <= 11'd0;
            v_meas_q      <= 11'd0;
            err_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            hb_q          <= hb_d;
            vb_q          <= vb_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            good_q        <= good_d;
            h_seen_q      <= h_seen_d;
            frame_bad_q   <= frame_bad_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            h_meas_q      <= h_meas_d;
            v_meas_q      <= v_meas_d;
            err_q         <= err_d;
        end
    end

    assign x            = h_cnt_q;
    assign y            = v_cnt_q;
    assign de           = de_q;
    assign rgb_out      = rgb_q;
    assign hsync_out    = hsync_q;
    assign vsync_out    = vsync_q;
    assign frame_start  = frame_start_q;
    assign locked       = locked_q;
    assign h_total_meas = h_meas_q;
    assign v_total_meas = v_meas_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_vga_timing_recover.sv
// Directed bench for vga_timing_recover using a reduced raster (6x5 clocks,
// 4x3 active) so that lock, relock and saturation scenarios stay short.
module tb_vga_timing_recover;

    localparam int HT    = 6;
    localparam int VT    = 5;
    localparam int HACT  = 4;
    localparam int VACT  = 3;
    localparam int LOCKN = 2;
    localparam int BOUND = 4 * HT * VT + 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    vga_if       vif();
    logic [10:0] x;
    logic [10:0] y;
    logic        de;
    logic [11:0] rgb_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        frame_start;
    logic        locked;
    logic [10:0] h_total_meas;
    logic [10:0] v_total_meas;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    int gen_h     = 1;
    int gen_v     = 1;
    int line_len  = HT;
    int frame_len = VT;
    bit stuck     = 1'b0;

    logic        prev_hb    = 1'b0;
    logic        prev_vb    = 1'b0;
    bit          last_hfall = 1'b0;
    bit          last_vfall = 1'b0;
    logic [11:0] last_rgb   = 12'd0;
    logic        last_hs    = 1'b0;
    logic        last_vs    = 1'b0;
    logic        last_de    = 1'b0;
    int          last_h     = 0;
    int          last_v     = 0;

    vga_timing_recover #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .LOCK_FRAMES (LOCKN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (vif),
        .x            (x),
        .y            (y),
        .de           (de),
        .rgb_out      (rgb_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .frame_start  (frame_start),
        .locked       (locked),
        .h_total_meas (h_total_meas),
        .v_total_meas (v_total_meas),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Apply one generator pixel, clock it in, sample #1 after the edge.
    task automatic clk_pixel();
        logic hb;
        logic vb;
        hb = stuck ? 1'b0 : (gen_h >= HACT);
        vb = stuck ? 1'b0 : (gen_v >= VACT);
        vif.hblnk  = hb;
        vif.vblnk  = vb;
        vif.hsync  = (gen_h == HACT + 1);
        vif.vsync  = (gen_v == VACT + 1);
        vif.rgb    = 12'($urandom_range(0, 4095));
        vif.hcount = 11'(gen_h);
        vif.vcount = 11'(gen_v);
        last_hfall = !rst && prev_hb && !hb;
        last_vfall = !rst && prev_vb && !vb;
        prev_hb    = rst ? 1'b0 : hb;
        prev_vb    = rst ? 1'b0 : vb;
        last_rgb   = vif.rgb;
        last_hs    = vif.hsync;
        last_vs    = vif.vsync;
        last_de    = !hb && !vb;
        last_h     = gen_h;
        last_v     = gen_v;
        @(posedge clk);
        #1;
        if (!stuck) begin
            if (gen_h >= line_len - 1) begin
                gen_h    = 0;
                line_len = HT;
                if (gen_v >= frame_len - 1) begin
                    gen_v     = 0;
                    frame_len = VT;
                end else begin
                    gen_v++;
                end
            end else begin
                gen_h++;
            end
        end
    endtask

    task automatic run_to_vfall();
        int n = 0;
        do begin
            clk_pixel();
            n++;
        end while (!last_vfall && n < BOUND);
        checks++;
        if (!last_vfall) begin
            errors++;
            $display("[TB] FAIL vfall_timeout got no vblnk fall want fall within %0d cycles", BOUND);
        end
    endtask

    task automatic run_to_hfall();
        int n = 0;
        do begin
            clk_pixel();
            n++;
        end while (!last_hfall && n < BOUND);
        checks++;
        if (!last_hfall) begin
            errors++;
            $display("[TB] FAIL hfall_timeout got no hblnk fall want fall within %0d cycles", BOUND);
        end
    endtask

    task automatic wait_gen(input int h, input int v);
        int n = 0;
        while (!(gen_h == h && gen_v == v) && n < BOUND) begin
            clk_pixel();
            n++;
        end
        checks++;
        if (!(gen_h == h && gen_v == v)) begin
            errors++;
            $display("[TB] FAIL gen_position got (%0d,%0d) want (%0d,%0d)", gen_h, gen_v, h, v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) clk_pixel();
        checks += 11;
        if (x !== 11'd0)            begin errors++; $display("[TB] FAIL reset_x got %0d want 0", x); end
        if (y !== 11'd0)            begin errors++; $display("[TB] FAIL reset_y got %0d want 0", y); end
        if (de !== 1'b0)            begin errors++; $display("[TB] FAIL reset_de got %b want 0", de); end
        if (rgb_out !== 12'd0)      begin errors++; $display("[TB] FAIL reset_rgb got %h want 0", rgb_out); end
        if (hsync_out !== 1'b0)     begin errors++; $display("[TB] FAIL reset_hsync got %b want 0", hsync_out); end
        if (vsync_out !== 1'b0)     begin errors++; $display("[TB] FAIL reset_vsync got %b want 0", vsync_out); end
        if (frame_start !== 1'b0)   begin errors++; $display("[TB] FAIL reset_frame_start got %b want 0", frame_start); end
        if (locked !== 1'b0)        begin errors++; $display("[TB] FAIL reset_locked got %b want 0", locked); end
        if (h_total_meas !== 11'd0) begin errors++; $display("[TB] FAIL reset_h_meas got %0d want 0", h_total_meas); end
        if (v_total_meas !== 11'd0) begin errors++; $display("[TB] FAIL reset_v_meas got %0d want 0", v_total_meas); end
        if (err_count !== 8'd0)     begin errors++; $display("[TB] FAIL reset_err got %0d want 0", err_count); end
    endtask

    task automatic test_lock();
        rst = 1'b0;
        run_to_vfall();
        run_to_vfall();
        checks += 2;
        if (locked !== 1'b0)      begin errors++; $display("[TB] FAIL lock_edge2 got %b want 0", locked); end
        if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL lock_frame_start got %b want 1", frame_start); end
        run_to_vfall();
        checks += 4;
        if (locked !== 1'b1)             begin errors++; $display("[TB] FAIL lock_edge3 got %b want 1", locked); end
        if (h_total_meas !== 11'(HT))    begin errors++; $display("[TB] FAIL lock_h_meas got %0d want %0d", h_total_meas, HT); end
        if (v_total_meas !== 11'(VT))    begin errors++; $display("[TB] FAIL lock_v_meas got %0d want %0d", v_total_meas, VT); end
        if (err_count !== 8'd0)          begin errors++; $display("[TB] FAIL lock_err got %0d want 0", err_count); end
    endtask

    task automatic test_coordinates();
        int n = 0;
        run_to_vfall();
        checks += 4;
        if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL coord_frame_start got %b want 1", frame_start); end
        if (de !== 1'b1)          begin errors++; $display("[TB] FAIL coord_first_de got %b want 1", de); end
        if (x !== 11'd0)          begin errors++; $display("[TB] FAIL coord_first_x got %0d want 0", x); end
        if (y !== 11'd0)          begin errors++; $display("[TB] FAIL coord_first_y got %0d want 0", y); end
        do begin
            clk_pixel();
            n++;
            checks += 3;
            if (rgb_out !== last_rgb)
                begin errors++; $display("[TB] FAIL coord_rgb got %h want %h", rgb_out, last_rgb); end
            if ({de, hsync_out, vsync_out} !== {last_de, last_hs, last_vs})
                begin errors++; $display("[TB] FAIL coord_ctrl got %b%b%b want %b%b%b", de, hsync_out, vsync_out, last_de, last_hs, last_vs); end
            if ({x, y} !== {11'(last_h), 11'(last_v)})
                begin errors++; $display("[TB] FAIL coord_xy got (%0d,%0d) want (%0d,%0d)", x, y, last_h, last_v); end
        end while (!(last_h == HACT - 1 && last_v == VACT - 1) && n < BOUND);
        checks += 3;
        if (x !== 11'(HACT - 1)) begin errors++; $display("[TB] FAIL coord_last_x got %0d want %0d", x, HACT - 1); end
        if (y !== 11'(VACT - 1)) begin errors++; $display("[TB] FAIL coord_last_y got %0d want %0d", y, VACT - 1); end
        if (de !== 1'b1)         begin errors++; $display("[TB] FAIL coord_last_de got %b want 1", de); end
        run_to_vfall();
        checks += 2;
        if (locked !== 1'b1)    begin errors++; $display("[TB] FAIL coord_locked got %b want 1", locked); end
        if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL coord_err got %0d want 0", err_count); end
    endtask

    task automatic test_short_line();
        wait_gen(1, 1);
        line_len = HT - 1;
        run_to_hfall();
        checks += 3;
        if (locked !== 1'b0)              begin errors++; $display("[TB] FAIL short_line_locked got %b want 0", locked); end
        if (err_count !== 8'd1)           begin errors++; $display("[TB] FAIL short_line_err got %0d want 1", err_count); end
        if (h_total_meas !== 11'(HT - 1)) begin errors++; $display("[TB] FAIL short_line_meas got %0d want %0d", h_total_meas, HT - 1); end
        run_to_vfall();
        run_to_vfall();
        checks++;
        if (locked !== 1'b0) begin errors++; $display("[TB] FAIL short_line_relock_early got %b want 0", locked); end
        run_to_vfall();
        checks++;
        if (locked !== 1'b1) begin errors++; $display("[TB] FAIL short_line_relock got %b want 1", locked); end
    endtask

    task automatic test_timeout();
        run_to_hfall();
        stuck = 1'b1;
        repeat (2047) clk_pixel();
        checks += 2;
        if (locked !== 1'b1)     begin errors++; $display("[TB] FAIL timeout_early got %b want 1", locked); end
        if (x !== 11'd2047)      begin errors++; $display("[TB] FAIL timeout_x got %0d want 2047", x); end
        clk_pixel();
        checks += 2;
        if (locked !== 1'b0)     begin errors++; $display("[TB] FAIL timeout_locked got %b want 0", locked); end
        if (err_count !== 8'd2)  begin errors++; $display("[TB] FAIL timeout_err got %0d want 2", err_count); end
        clk_pixel();
        checks += 2;
        if (x !== 11'd2047)      begin errors++; $display("[TB] FAIL timeout_x_sat got %0d want 2047", x); end
        if (err_count !== 8'd2)  begin errors++; $display("[TB] FAIL timeout_err_once got %0d want 2", err_count); end
        stuck = 1'b0;
        gen_h = HACT;
        gen_v = VACT;
    endtask

    task automatic test_short_frame();
        run_to_vfall();
        frame_len = VT - 1;
        run_to_vfall();
        checks += 2;
        if (locked !== 1'b0)              begin errors++; $display("[TB] FAIL short_frame_locked got %b want 0", locked); end
        if (v_total_meas !== 11'(VT - 1)) begin errors++; $display("[TB] FAIL short_frame_meas got %0d want %0d", v_total_meas, VT - 1); end
        run_to_vfall();
        checks++;
        if (locked !== 1'b0) begin errors++; $display("[TB] FAIL short_frame_good_reset got %b want 0", locked); end
        run_to_vfall();
        checks += 2;
        if (locked !== 1'b1)    begin errors++; $display("[TB] FAIL short_frame_relock got %b want 1", locked); end
        if (err_count !== 8'd2) begin errors++; $display("[TB] FAIL short_frame_err got %0d want 2", err_count); end
    endtask

    task automatic test_saturation();
        int exp_err = 2;
        for (int i = 0; i < 300; i++) begin
            wait_gen(1, 1);
            line_len = HT - 1;
            run_to_hfall();
            exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
            checks++;
            if (err_count !== 8'(exp_err))
                begin errors++; $display("[TB] FAIL sat_step%0d got %0d want %0d", i, err_count, exp_err); end
            run_to_vfall();
            run_to_vfall();
            run_to_vfall();
        end
        checks += 2;
        if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_final got %0d want 255", err_count); end
        if (locked !== 1'b1)      begin errors++; $display("[TB] FAIL sat_locked got %b want 1", locked); end
    endtask

    task automatic test_reset_midframe();
        wait_gen(2, 1);
        rst = 1'b1;
        clk_pixel();
        rst = 1'b0;
        checks += 4;
        if ({x, y} !== 22'd0)
            begin errors++; $display("[TB] FAIL midrst_xy got (%0d,%0d) want (0,0)", x, y); end
        if ({de, rgb_out, hsync_out, vsync_out, frame_start} !== 16'd0)
            begin errors++; $display("[TB] FAIL midrst_stream got %b/%h/%b%b%b want 0", de, rgb_out, hsync_out, vsync_out, frame_start); end
        if (locked !== 1'b0)
            begin errors++; $display("[TB] FAIL midrst_locked got %b want 0", locked); end
        if ({h_total_meas, v_total_meas, err_count} !== 30'd0)
            begin errors++; $display("[TB] FAIL midrst_status got %0d/%0d/%0d want 0/0/0", h_total_meas, v_total_meas, err_count); end
        run_to_vfall();
        run_to_vfall();
        checks++;
        if (locked !== 1'b0) begin errors++; $display("[TB] FAIL midrst_relock_early got %b want 0", locked); end
        run_to_vfall();
        checks++;
        if (locked !== 1'b1) begin errors++; $display("[TB] FAIL midrst_relock got %b want 1", locked); end
    endtask

    // Scenario sequence; each task checks its own results.
    initial begin
        test_reset();
        test_lock();
        test_coordinates();
        test_short_line();
        test_timeout();
        test_short_frame();
        test_saturation();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
